// File: rtl/video_ctrl_regs_if.sv
// Pipelined Wishbone register-access bus (32-bit data, word-indexed addressing).
interface wishbone_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    logic [31:0] rdata;
    logic        ack;
    logic        stall;
    logic        err;
    logic        rty;

    modport SLAVE  (input  cyc, stb, we, addr, wdata, sel,
                    output rdata, ack, stall, err, rty);
    modport MASTER (output cyc, stb, we, addr, wdata, sel,
                    input  rdata, ack, stall, err, rty);
endinterface

// File: rtl/video_ctrl_regs.sv
// Video core layer configuration registers: shadow/active pairs with
// frame-synchronous atomic commit, frame counter and maskable interrupts.

module video_ctrl_layer #(
    parameter int CFG_W  = 16,
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              wr_cfg,
    input  logic              wr_addr,
    input  logic [31:0]       wdata,
    input  logic [3:0]        sel,
    input  logic              commit,
    output logic [CFG_W-1:0]  shadow_cfg,
    output logic [ADDR_W-1:0] shadow_addr,
    output logic [CFG_W-1:0]  act_cfg,
    output logic [ADDR_W-1:0] act_addr
);
    logic [31:0] be_mask;
    logic        unused_bus;

    assign be_mask    = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    assign unused_bus = ^{wdata, be_mask};

    // Active copies read the pre-edge shadow, so a same-cycle shadow write
    // lands in the shadow only and waits for the next commit.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            shadow_cfg  <= '0;
            shadow_addr <= '0;
            act_cfg     <= '0;
            act_addr    <= '0;
        end else begin
            if (wr_cfg)
                shadow_cfg <= (shadow_cfg & ~be_mask[CFG_W-1:0]) |
                              (wdata[CFG_W-1:0] & be_mask[CFG_W-1:0]);
            if (wr_addr)
                shadow_addr <= (shadow_addr & ~be_mask[ADDR_W-1:0]) |
                               (wdata[ADDR_W-1:0] & be_mask[ADDR_W-1:0]);
            if (commit) begin
                act_cfg  <= shadow_cfg;
                act_addr <= shadow_addr;
            end
        end
    end
endmodule

module video_ctrl_regs #(
    parameter int NUM_LAYERS = 2,
    parameter int CFG_W      = 16,
    parameter int ADDR_W     = 32
) (
    input  logic                         clk_i,
    input  logic                         rstn_i,
    wishbone_if.SLAVE                    config_if,
    input  logic                         frame_start_i,
    output logic [NUM_LAYERS*CFG_W-1:0]  cfg_o,
    output logic [NUM_LAYERS*ADDR_W-1:0] addr_o,
    output logic                         irq_o
);
    localparam int NUM_REGS = 4 + 2*NUM_LAYERS;
    localparam int IDX_W    = $clog2(NUM_REGS);
    localparam int STAGES   = 1;

    logic             req, wr, wr_ctrl, wr_stat, commit_fire;
    logic [IDX_W-1:0] idx;
    logic [STAGES:0]  vld_pipe;
    logic [31:0]      rd_val, rdata_q;
    logic             commit_pending, frame_ie, commit_ie, frame_f, commit_f;
    logic [15:0]      frame_cnt;
    logic             unused_addr;

    logic [NUM_LAYERS-1:0][CFG_W-1:0]  shadow_cfg, act_cfg;
    logic [NUM_LAYERS-1:0][ADDR_W-1:0] shadow_addr, act_addr;

    assign req         = config_if.cyc & config_if.stb;
    assign wr          = req & config_if.we;
    assign idx         = config_if.addr[IDX_W-1:0];
    assign wr_ctrl     = wr & (idx == IDX_W'(0)) & config_if.sel[0];
    assign wr_stat     = wr & (idx == IDX_W'(1)) & config_if.sel[0];
    assign commit_fire = frame_start_i & commit_pending;
    assign unused_addr = ^config_if.addr[31:IDX_W];

    assign vld_pipe[0]      = req;
    assign config_if.ack    = vld_pipe[STAGES];
    assign config_if.rdata  = rdata_q;
    assign config_if.stall  = 1'b0;
    assign config_if.err    = 1'b0;
    assign config_if.rty    = 1'b0;

    assign cfg_o  = act_cfg;
    assign addr_o = act_addr;

    generate
        for (genvar l = 0; l < NUM_LAYERS; l++) begin : g_layer
            video_ctrl_layer #(.CFG_W(CFG_W), .ADDR_W(ADDR_W)) u_layer (
                .clk_i       (clk_i),
                .rstn_i      (rstn_i),
                .wr_cfg      (wr && (idx == IDX_W'(4 + 2*l))),
                .wr_addr     (wr && (idx == IDX_W'(5 + 2*l))),
                .wdata       (config_if.wdata),
                .sel         (config_if.sel),
                .commit      (commit_fire),
                .shadow_cfg  (shadow_cfg[l]),
                .shadow_addr (shadow_addr[l]),
                .act_cfg     (act_cfg[l]),
                .act_addr    (act_addr[l])
            );
        end
    endgenerate

    always_comb begin
        rd_val = '0;
        case (idx)
            IDX_W'(0): rd_val[2:0]  = {commit_ie, frame_ie, commit_pending};
            IDX_W'(1): rd_val[1:0]  = {commit_f, frame_f};
            IDX_W'(2): rd_val[15:0] = frame_cnt;
            default:   ;
        endcase
        for (int l = 0; l < NUM_LAYERS; l++) begin
            if (idx == IDX_W'(4 + 2*l)) rd_val[CFG_W-1:0]  = shadow_cfg[l];
            if (idx == IDX_W'(5 + 2*l)) rd_val[ADDR_W-1:0] = shadow_addr[l];
        end
    end

    // Hardware sets take priority over software clears on the same edge;
    // a commit requested on a frame-start edge waits for the next frame.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            vld_pipe[STAGES:1] <= '0;
            rdata_q            <= '0;
            commit_pending     <= 1'b0;
            frame_ie           <= 1'b0;
            commit_ie          <= 1'b0;
            frame_f            <= 1'b0;
            commit_f           <= 1'b0;
            frame_cnt          <= '0;
            irq_o              <= 1'b0;
        end else begin
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
            if (req)
                rdata_q <= rd_val;
            if (frame_start_i)
                frame_cnt <= frame_cnt + 16'd1;
            if (wr_ctrl)
                {commit_ie, frame_ie} <= config_if.wdata[2:1];
            if (wr_ctrl && config_if.wdata[0])
                commit_pending <= 1'b1;
            else if (commit_fire)
                commit_pending <= 1'b0;
            if (frame_start_i)
                frame_f <= 1'b1;
            else if (wr_stat && config_if.wdata[0])
                frame_f <= 1'b0;
            if (commit_fire)
                commit_f <= 1'b1;
            else if (wr_stat && config_if.wdata[1])
                commit_f <= 1'b0;
            irq_o <= (frame_f & frame_ie) | (commit_f & commit_ie);
        end
    end
endmodule

// File: tb/tb_video_ctrl_regs.sv
// Directed bench for video_ctrl_regs: bus responses go through a scoreboard
// queue checked by an independent ack monitor.
module tb_video_ctrl_regs;
    logic        clk = 1'b0;
    logic        rstn;
    logic        fs;
    logic [31:0] cfg_o;
    logic [63:0] addr_o;
    logic        irq_o;

    int tests = 0;
    int fails = 0;
    int cyc_cnt = 0;

    typedef struct {
        int          cyc;
        bit          chk;
        logic [31:0] exp;
        int          idx;
    } exp_t;
    exp_t exp_q[$];

    wishbone_if wb();

    video_ctrl_regs #(.NUM_LAYERS(2), .CFG_W(16), .ADDR_W(32)) dut (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .config_if     (wb),
        .frame_start_i (fs),
        .cfg_o         (cfg_o),
        .addr_o        (addr_o),
        .irq_o         (irq_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Monitor: each ack must match the oldest outstanding request, one cycle late.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0 && exp_q[0].cyc + 1 < cyc_cnt) begin
            e = exp_q.pop_front();
            tests++;
            fails++;
            $display("FAIL ack_missing idx %0d: no ack by cycle %0d, required at cycle %0d", e.idx, cyc_cnt, e.cyc + 1);
        end
        if (wb.ack === 1'b1) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL ack_unexpected: ack with rdata %h, no request outstanding", wb.rdata);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc + 1 != cyc_cnt || (e.chk && wb.rdata !== e.exp)) begin
                    fails++;
                    $display("FAIL bus idx %0d: got rdata %h at cycle %0d, required %h at cycle %0d",
                             e.idx, wb.rdata, cyc_cnt, e.exp, e.cyc + 1);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Called at posedge+1; issues one request which is sampled on the next edge.
    task automatic drive(input bit we, input int idx, input logic [31:0] d,
                         input logic [3:0] sel, input bit chk, input logic [31:0] exp);
        exp_t e;
        wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = we;
        wb.addr = idx; wb.wdata = d; wb.sel = sel;
        e.cyc = cyc_cnt; e.chk = chk; e.exp = exp; e.idx = idx;
        exp_q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0; wb.sel = 4'h0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wr(input int idx, input logic [31:0] d, input logic [3:0] sel);
        drive(1'b1, idx, d, sel, 1'b0, 32'h0);
        idle(1);
    endtask

    task automatic rd(input int idx, input logic [31:0] exp);
        drive(1'b0, idx, 32'h0, 4'h0, 1'b1, exp);
        idle(1);
    endtask

    task automatic frame();
        fs = 1'b1;
        @(posedge clk); #1;
        fs = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; fs = 1'b0;
        wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
        wb.addr = '0; wb.wdata = '0; wb.sel = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cfg", {32'h0, cfg_o}, 64'h0);
        check("rst_addr", addr_o, 64'h0);
        check("rst_irq", {63'h0, irq_o}, 64'h0);
        rstn = 1'b1;
        idle(2);

        // 1: every index reads 0 after reset, back-to-back
        for (int i = 0; i < 8; i++) drive(1'b0, i, 32'h0, 4'h0, 1'b1, 32'h0);
        idle(2);

        // 2: shadow write invisible until commit
        wr(7, 32'h8000_1000, 4'hF);
        frame(); idle(1); frame(); idle(1);
        check("no_commit_addr", addr_o, 64'h0);
        rd(2, 32'd2);
        rd(7, 32'h8000_1000);
        wr(0, 32'h1, 4'h1);
        rd(0, 32'h1);
        frame();
        check("commit_addr", addr_o, 64'h8000_1000_0000_0000);
        rd(0, 32'h0);
        rd(1, 32'h3);
        check("irq_masked", {63'h0, irq_o}, 64'h0);

        // 3: commit write on the frame-start edge defers the copy
        wr(1, 32'h3, 4'h1);
        wr(4, 32'h1234, 4'hF);
        fs = 1'b1; drive(1'b1, 0, 32'h1, 4'h1, 1'b0, 32'h0); fs = 1'b0;
        idle(1);
        check("deferred_cfg", {32'h0, cfg_o}, 64'h0);
        rd(1, 32'h1);
        rd(0, 32'h1);
        frame();
        check("late_commit_cfg", {32'h0, cfg_o}, 64'h0000_1234);
        rd(1, 32'h3);
        rd(0, 32'h0);

        // 4: commit interrupt, clear latency, set-beats-clear
        wr(1, 32'h3, 4'h1);
        wr(0, 32'h4, 4'h1);
        check("irq_idle", {63'h0, irq_o}, 64'h0);
        wr(0, 32'h5, 4'h1);
        frame();
        idle(1);
        check("irq_commit", {63'h0, irq_o}, 64'h1);
        drive(1'b1, 1, 32'h2, 4'h1, 1'b0, 32'h0);
        check("irq_hold_1cyc", {63'h0, irq_o}, 64'h1);
        idle(1);
        check("irq_cleared", {63'h0, irq_o}, 64'h0);
        rd(1, 32'h1);
        wr(0, 32'h5, 4'h1);
        fs = 1'b1; drive(1'b1, 1, 32'h2, 4'h1, 1'b0, 32'h0); fs = 1'b0;
        rd(1, 32'h3);
        check("irq_set_wins", {63'h0, irq_o}, 64'h1);
        wr(0, 32'h0, 4'h1);
        wr(1, 32'h3, 4'h1);
        idle(1);
        check("irq_off", {63'h0, irq_o}, 64'h0);

        // 5: byte enables, shadow write during copy, reserved/aliased indices
        wr(4, 32'h0, 4'hF);
        wr(4, 32'hAABB_CCDD, 4'b0010);
        rd(4, 32'h0000_CC00);
        check("sel_cfg_hold", {32'h0, cfg_o}, 64'h0000_1234);
        wr(0, 32'h1, 4'h1);
        fs = 1'b1; drive(1'b1, 4, 32'h5678, 4'hF, 1'b0, 32'h0); fs = 1'b0;
        idle(1);
        check("copy_old_shadow", {32'h0, cfg_o}, 64'h0000_CC00);
        rd(4, 32'h5678);
        rd(2, 32'd8);
        wr(1, 32'h3, 4'h1);
        wr(3, 32'hFFFF_FFFF, 4'hF);
        rd(3, 32'h0);
        wr(9, 32'hFFFF_FFFF, 4'hF);
        rd(9, 32'h0);
        rd(0, 32'h0);
        rd(1, 32'h0);
        check("idx9_cfg", {32'h0, cfg_o}, 64'h0000_CC00);
        check("idx9_addr", addr_o, 64'h8000_1000_0000_0000);

        // 6: frame counter wrap, then pipelined reads
        fs = 1'b1;
        repeat (65527) @(posedge clk);
        #1; fs = 1'b0;
        rd(2, 32'hFFFF);
        frame();
        rd(2, 32'h0);
        drive(1'b0, 2, 32'h0, 4'h0, 1'b1, 32'h0);
        drive(1'b0, 4, 32'h0, 4'h0, 1'b1, 32'h5678);
        drive(1'b0, 7, 32'h0, 4'h0, 1'b1, 32'h8000_1000);
        drive(1'b0, 1, 32'h0, 4'h0, 1'b1, 32'h1);
        idle(2);

        // Reset while a read is in flight drops its ack and the pending commit
        wr(0, 32'h1, 4'h1);
        drive(1'b0, 0, 32'h0, 4'h0, 1'b1, 32'h1);
        rstn = 1'b0;
        wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
        exp_q.delete();
        #1;
        check("rst_drops_ack", {63'h0, wb.ack}, 64'h0);
        @(posedge clk); #1;
        rstn = 1'b1;
        check("rst2_cfg", {32'h0, cfg_o}, 64'h0);
        check("rst2_addr", addr_o, 64'h0);
        idle(1);
        rd(0, 32'h0);
        rd(2, 32'h0);
        frame();
        check("rst2_no_commit", addr_o, 64'h0);
        idle(3);
        check("queue_drained", 64'(exp_q.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
